// File: rtl/wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : wb_scoreboard
//  Purpose  : Round-robin write-back scheduler for ALU/MEM/FPU results plus a
//             per-register pending scoreboard that stalls issue on RAW/WAW.
//  Revision : 1.0  initial release
// ============================================================================
module wb_scoreboard #(
  parameter int NPROD = 3
) (
  input  logic                clk,
  input  logic                rst,
  input  logic                iss_valid,
  input  logic [1:0]          iss_regwrite,
  input  logic [4:0]          iss_dst,
  input  logic [1:0]          iss_s_file,
  input  logic [1:0]          iss_t_file,
  input  logic [4:0]          iss_s_idx,
  input  logic [4:0]          iss_t_idx,
  output logic                iss_ready,
  input  logic [NPROD-1:0]    p_valid,
  output logic [NPROD-1:0]    p_ready,
  input  logic [2*NPROD-1:0]  p_regwrite,
  input  logic [5*NPROD-1:0]  p_dst,
  input  logic [32*NPROD-1:0] p_data,
  output logic [1:0]          wb_regwrite,
  output logic [4:0]          wb_dst,
  output logic [31:0]         wb_data,
  output logic [31:0]         gpr_pending,
  output logic [31:0]         fpr_pending,
  output logic                idle
);

  localparam int                 C_PTR_W    = (NPROD > 1) ? $clog2(NPROD) : 1;
  localparam logic [1:0]         C_RW_GPR   = 2'b01;
  localparam logic [1:0]         C_RW_FPR   = 2'b10;
  localparam logic [C_PTR_W-1:0] C_LAST_RST = C_PTR_W'(NPROD - 1);

  logic [31:0]        r_gpr;
  logic [31:0]        r_fpr;
  logic [1:0]         r_wb_rw;
  logic [4:0]         r_wb_dst;
  logic [31:0]        r_wb_data;
  logic [C_PTR_W-1:0] r_last;

  logic               w_s_haz;
  logic               w_t_haz;
  logic               w_d_haz;
  logic               w_issue;
  logic [C_PTR_W-1:0] w_cand;
  logic [C_PTR_W-1:0] w_gnt_idx;
  logic               w_gnt_any;
  logic [NPROD-1:0]   w_grant;
  logic [1:0]         w_gnt_rw;
  logic [4:0]         w_gnt_dst;
  logic [31:0]        w_gnt_data;
  logic [31:0]        w_gpr_set;
  logic [31:0]        w_gpr_clr;
  logic [31:0]        w_fpr_set;
  logic [31:0]        w_fpr_clr;

  function automatic logic pend_hit(input logic [1:0]  file,
                                    input logic [4:0]  idx,
                                    input logic [31:0] gpr,
                                    input logic [31:0] fpr);
    case (file)
      C_RW_GPR: pend_hit = gpr[idx];
      C_RW_FPR: pend_hit = fpr[idx];
      default:  pend_hit = 1'b0;
    endcase
  endfunction

  // Hazards look only at registered pending bits: no same-cycle bypass.
  assign w_s_haz   = pend_hit(iss_s_file,   iss_s_idx, r_gpr, r_fpr);
  assign w_t_haz   = pend_hit(iss_t_file,   iss_t_idx, r_gpr, r_fpr);
  assign w_d_haz   = pend_hit(iss_regwrite, iss_dst,   r_gpr, r_fpr);
  assign iss_ready = ~(w_s_haz | w_t_haz | w_d_haz);
  assign w_issue   = iss_valid & iss_ready;

  // Search starts one past the last winner, wrapping modulo NPROD.
  always_comb begin
    w_cand    = '0;
    w_gnt_idx = '0;
    w_gnt_any = 1'b0;
    w_grant   = '0;
    for (int k = 1; k <= NPROD; k++) begin
      w_cand = C_PTR_W'((int'(r_last) + k) % NPROD);
      if (!w_gnt_any && p_valid[w_cand]) begin
        w_gnt_any = 1'b1;
        w_gnt_idx = w_cand;
      end
    end
    if (w_gnt_any) begin
      w_grant[w_gnt_idx] = 1'b1;
    end
  end

  assign p_ready    = rst ? '0 : w_grant;
  assign w_gnt_rw   = p_regwrite[int'(w_gnt_idx)*2 +: 2];
  assign w_gnt_dst  = p_dst[int'(w_gnt_idx)*5 +: 5];
  assign w_gnt_data = p_data[int'(w_gnt_idx)*32 +: 32];

  assign w_gpr_set = (w_issue && iss_regwrite == C_RW_GPR) ? (32'd1 << iss_dst)  : 32'd0;
  assign w_fpr_set = (w_issue && iss_regwrite == C_RW_FPR) ? (32'd1 << iss_dst)  : 32'd0;
  assign w_gpr_clr = (r_wb_rw == C_RW_GPR)                 ? (32'd1 << r_wb_dst) : 32'd0;
  assign w_fpr_clr = (r_wb_rw == C_RW_FPR)                 ? (32'd1 << r_wb_dst) : 32'd0;

  always_ff @(posedge clk) begin
    if (rst) begin
      r_gpr     <= '0;
      r_fpr     <= '0;
      r_wb_rw   <= 2'b00;
      r_wb_dst  <= '0;
      r_wb_data <= '0;
      r_last    <= C_LAST_RST;
    end else begin
      // Set is applied after clear so it wins on a same-bit collision.
      r_gpr <= (r_gpr & ~w_gpr_clr) | w_gpr_set;
      r_fpr <= (r_fpr & ~w_fpr_clr) | w_fpr_set;
      if (w_gnt_any) begin
        r_wb_rw   <= (w_gnt_rw == C_RW_GPR || w_gnt_rw == C_RW_FPR) ? w_gnt_rw : 2'b00;
        r_wb_dst  <= w_gnt_dst;
        r_wb_data <= w_gnt_data;
        r_last    <= w_gnt_idx;
      end else begin
        r_wb_rw   <= 2'b00;
      end
    end
  end

  a_no_set_clr_collision: assert property (@(posedge clk) disable iff (rst)
    ((w_gpr_set & w_gpr_clr) == 32'd0) && ((w_fpr_set & w_fpr_clr) == 32'd0));

  assign wb_regwrite = r_wb_rw;
  assign wb_dst      = r_wb_dst;
  assign wb_data     = r_wb_data;
  assign gpr_pending = r_gpr;
  assign fpr_pending = r_fpr;
  assign idle        = (r_gpr == 32'd0) && (r_fpr == 32'd0) && (r_wb_rw == 2'b00);

endmodule
`default_nettype wire

// File: tb/tb_wb_scoreboard.sv
`default_nettype none
// ============================================================================
//  Module   : tb_wb_scoreboard
//  Purpose  : Directed scenarios plus randomized traffic against a
//             pending-set / round-robin reference model.
//  Revision : 1.0  initial release
// ============================================================================
module tb_wb_scoreboard;
  localparam int NPROD = 3;

  logic                clk;
  logic                rst;
  logic                iss_valid;
  logic [1:0]          iss_regwrite;
  logic [4:0]          iss_dst;
  logic [1:0]          iss_s_file;
  logic [1:0]          iss_t_file;
  logic [4:0]          iss_s_idx;
  logic [4:0]          iss_t_idx;
  logic                iss_ready;
  logic [NPROD-1:0]    p_valid;
  logic [NPROD-1:0]    p_ready;
  logic [2*NPROD-1:0]  p_regwrite;
  logic [5*NPROD-1:0]  p_dst;
  logic [32*NPROD-1:0] p_data;
  logic [1:0]          wb_regwrite;
  logic [4:0]          wb_dst;
  logic [31:0]         wb_data;
  logic [31:0]         gpr_pending;
  logic [31:0]         fpr_pending;
  logic                idle;

  int errors = 0;
  int checks = 0;

  wb_scoreboard #(.NPROD(NPROD)) dut (
    .clk(clk), .rst(rst),
    .iss_valid(iss_valid), .iss_regwrite(iss_regwrite), .iss_dst(iss_dst),
    .iss_s_file(iss_s_file), .iss_t_file(iss_t_file),
    .iss_s_idx(iss_s_idx), .iss_t_idx(iss_t_idx), .iss_ready(iss_ready),
    .p_valid(p_valid), .p_ready(p_ready), .p_regwrite(p_regwrite),
    .p_dst(p_dst), .p_data(p_data),
    .wb_regwrite(wb_regwrite), .wb_dst(wb_dst), .wb_data(wb_data),
    .gpr_pending(gpr_pending), .fpr_pending(fpr_pending), .idle(idle)
  );

  initial begin
    clk = 1'b0;
    forever #5 clk = ~clk;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: got no finish, required finish before time limit");
    $fatal(1);
  end

  task automatic clear_inputs();
    iss_valid = 0; iss_regwrite = 0; iss_dst = 0;
    iss_s_file = 0; iss_t_file = 0; iss_s_idx = 0; iss_t_idx = 0;
    p_valid = 0; p_regwrite = 0; p_dst = 0; p_data = 0;
  endtask

  task automatic next_cycle();
    @(posedge clk);
    #1;
  endtask

  task automatic test_reset();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    next_cycle();
    p_valid = 3'b111;
    @(negedge clk);
    checks++; if (p_ready !== 3'b000) begin errors++; $display("FAIL reset_p_ready: got %b required 000", p_ready); end
    next_cycle();
    rst = 1'b0;
    p_valid = '0;
    @(negedge clk);
    checks++; if (wb_regwrite !== 2'b00) begin errors++; $display("FAIL reset_wb_regwrite: got %b required 00", wb_regwrite); end
    checks++; if (wb_dst !== 5'd0) begin errors++; $display("FAIL reset_wb_dst: got %0d required 0", wb_dst); end
    checks++; if (wb_data !== 32'd0) begin errors++; $display("FAIL reset_wb_data: got %h required 0", wb_data); end
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL reset_iss_ready: got %b required 1", iss_ready); end
    checks++; if (idle !== 1'b1) begin errors++; $display("FAIL reset_idle: got %b required 1", idle); end
    checks++; if (gpr_pending !== 32'd0 || fpr_pending !== 32'd0) begin errors++; $display("FAIL reset_pending: got %h/%h required 0/0", gpr_pending, fpr_pending); end
  endtask

  task automatic test_raw_stall();
    next_cycle();
    iss_valid = 1; iss_regwrite = 2'b01; iss_dst = 5'd5;
    @(negedge clk);
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL raw_first_issue: got %b required 1", iss_ready); end
    next_cycle();
    iss_valid = 0; iss_regwrite = 0; iss_dst = 0; iss_s_file = 2'b01; iss_s_idx = 5'd5;
    @(negedge clk);
    checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL raw_stall: got %b required 0", iss_ready); end
    checks++; if (gpr_pending !== 32'h20) begin errors++; $display("FAIL raw_pending_set: got %h required 00000020", gpr_pending); end
    next_cycle();
    p_valid = 3'b001; p_regwrite[1:0] = 2'b01; p_dst[4:0] = 5'd5; p_data[31:0] = 32'h1234;
    @(negedge clk);
    checks++; if (p_ready !== 3'b001) begin errors++; $display("FAIL raw_alu_grant: got %b required 001", p_ready); end
    next_cycle();
    p_valid = 0;
    @(negedge clk);
    checks++; if (wb_regwrite !== 2'b01 || wb_dst !== 5'd5 || wb_data !== 32'h1234) begin
      errors++; $display("FAIL raw_wb: got rw=%b dst=%0d data=%h required rw=01 dst=5 data=00001234", wb_regwrite, wb_dst, wb_data); end
    checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL raw_no_bypass: got %b required 0", iss_ready); end
    next_cycle();
    @(negedge clk);
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL raw_release: got %b required 1", iss_ready); end
    checks++; if (gpr_pending !== 32'd0 || idle !== 1'b1) begin errors++; $display("FAIL raw_cleared: got pend=%h idle=%b required 0 1", gpr_pending, idle); end
    next_cycle();
    clear_inputs();
  endtask

  task automatic test_round_robin();
    int exp_seq[11] = '{0, 1, 2, 0, 1, 2, 0, 2, 0, 2, 0};
    next_cycle();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    rst = 1'b0;
    p_dst  = {5'd2, 5'd1, 5'd0};
    p_data = {32'hA2, 32'hA1, 32'hA0};
    p_valid = 3'b111;
    for (int i = 0; i < 11; i++) begin
      @(negedge clk);
      checks++; if (p_ready !== (3'b001 << exp_seq[i])) begin
        errors++; $display("FAIL rr_grant step=%0d: got %b required %b", i, p_ready, 3'b001 << exp_seq[i]); end
      next_cycle();
      checks++; if (wb_data !== 32'hA0 + exp_seq[i]) begin
        errors++; $display("FAIL rr_wb_data step=%0d: got %h required %h", i, wb_data, 32'hA0 + exp_seq[i]); end
      if (i == 6) p_valid = 3'b101;
    end
    clear_inputs();
  endtask

  task automatic test_waw_file();
    next_cycle();
    iss_valid = 1; iss_regwrite = 2'b10; iss_dst = 5'd3;
    @(negedge clk);
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL waw_first: got %b required 1", iss_ready); end
    next_cycle();
    @(negedge clk);
    checks++; if (iss_ready !== 1'b0) begin errors++; $display("FAIL waw_stall: got %b required 0", iss_ready); end
    next_cycle();
    checks++; if (fpr_pending !== 32'h8) begin errors++; $display("FAIL waw_fpr: got %h required 00000008", fpr_pending); end
    iss_regwrite = 2'b01; iss_dst = 5'd3;
    @(negedge clk);
    checks++; if (iss_ready !== 1'b1) begin errors++; $display("FAIL waw_other_file: got %b required 1", iss_ready); end
    next_cycle();
    iss_valid = 0;
    checks++; if (gpr_pending !== 32'h8 || fpr_pending !== 32'h8) begin
      errors++; $display("FAIL waw_both: got %h/%h required 00000008/00000008", gpr_pending, fpr_pending); end
  endtask

  task automatic test_reset_midflight();
    iss_valid = 1; iss_regwrite = 2'b01; iss_dst = 5'd7;
    next_cycle();
    iss_regwrite = 2'b10; iss_dst = 5'd2;
    next_cycle();
    iss_valid = 0; iss_regwrite = 0; iss_dst = 0;
    checks++; if (gpr_pending !== 32'h88 || fpr_pending !== 32'h0c) begin
      errors++; $display("FAIL mid_setup: got %h/%h required 00000088/0000000c", gpr_pending, fpr_pending); end
    p_valid = 3'b100; p_regwrite[5:4] = 2'b10; p_dst[14:10] = 5'd2; p_data[95:64] = 32'hF00D;
    @(negedge clk);
    checks++; if (p_ready !== 3'b100) begin errors++; $display("FAIL mid_fpu_grant: got %b required 100", p_ready); end
    next_cycle();
    rst = 1'b1;
    @(negedge clk);
    checks++; if (p_ready !== 3'b000) begin errors++; $display("FAIL mid_p_ready_rst: got %b required 000", p_ready); end
    next_cycle();
    rst = 1'b0;
    clear_inputs();
    @(negedge clk);
    checks++; if (gpr_pending !== 32'd0 || fpr_pending !== 32'd0) begin
      errors++; $display("FAIL mid_pending: got %h/%h required 0/0", gpr_pending, fpr_pending); end
    checks++; if (wb_regwrite !== 2'b00 || idle !== 1'b1) begin
      errors++; $display("FAIL mid_wb: got rw=%b idle=%b required 00 1", wb_regwrite, idle); end
  endtask

  task automatic test_null_request();
    next_cycle();
    p_valid = 3'b010; p_regwrite[3:2] = 2'b00; p_dst[9:5] = 5'd9; p_data[63:32] = 32'h5555;
    @(negedge clk);
    checks++; if (p_ready !== 3'b010) begin errors++; $display("FAIL null_grant: got %b required 010", p_ready); end
    next_cycle();
    p_valid = 0;
    @(negedge clk);
    checks++; if (wb_regwrite !== 2'b00 || wb_dst !== 5'd9) begin
      errors++; $display("FAIL null_wb: got rw=%b dst=%0d required 00 9", wb_regwrite, wb_dst); end
    checks++; if (gpr_pending !== 32'd0 || fpr_pending !== 32'd0 || idle !== 1'b1) begin
      errors++; $display("FAIL null_state: got %h/%h idle=%b required 0/0 1", gpr_pending, fpr_pending, idle); end
    next_cycle();
    @(negedge clk);
    checks++; if (wb_dst !== 5'd9 || wb_data !== 32'h5555) begin
      errors++; $display("FAIL null_hold: got dst=%0d data=%h required 9 00005555", wb_dst, wb_data); end
  endtask

  task automatic test_random();
    bit          mg[32];
    bit          mf[32];
    int          mlast;
    logic [1:0]  mwb_rw;
    logic [4:0]  mwb_dst;
    logic [31:0] mwb_data;
    bit          pv[NPROD];
    logic [1:0]  prw[NPROD];
    logic [4:0]  pdst[NPROD];
    logic [31:0] pdat[NPROD];
    int          pwait[NPROD];
    logic [1:0]  pool_f[$];
    logic [4:0]  pool_d[$];
    int          g;
    bit          exp_rdy;
    bit          eidle;
    bit          draining;
    logic [31:0]      eg;
    logic [31:0]      ef;
    logic [NPROD-1:0] eready;

    next_cycle();
    rst = 1'b1;
    clear_inputs();
    next_cycle();
    rst = 1'b0;
    for (int r = 0; r < 32; r++) begin mg[r] = 0; mf[r] = 0; end
    mlast = NPROD - 1; mwb_rw = 0; mwb_dst = 0; mwb_data = 0;
    for (int i = 0; i < NPROD; i++) begin pv[i] = 0; prw[i] = 0; pdst[i] = 0; pdat[i] = 0; pwait[i] = 0; end

    for (int cyc = 0; cyc < 400; cyc++) begin
      draining = (cyc >= 320);
      for (int i = 0; i < NPROD; i++) begin
        if (!pv[i] && $urandom_range(0, 1) == 1) begin
          if (pool_f.size() > 0 && $urandom_range(0, 7) != 0) begin
            int j;
            j = $urandom_range(0, pool_f.size() - 1);
            prw[i] = pool_f[j]; pdst[i] = pool_d[j];
            pool_f.delete(j); pool_d.delete(j);
            pdat[i] = $urandom; pv[i] = 1;
          end else if (!draining) begin
            prw[i] = ($urandom_range(0, 1) == 1) ? 2'b11 : 2'b00;
            pdst[i] = 5'($urandom_range(0, 31)); pdat[i] = $urandom; pv[i] = 1;
          end
        end
        p_valid[i] = pv[i];
        p_regwrite[2*i +: 2] = prw[i];
        p_dst[5*i +: 5] = pdst[i];
        p_data[32*i +: 32] = pdat[i];
      end
      iss_valid    = !draining && ($urandom_range(0, 1) == 1);
      iss_regwrite = 2'($urandom_range(0, 3));
      iss_dst      = 5'($urandom_range(0, 7));
      iss_s_file   = 2'($urandom_range(0, 3));
      iss_s_idx    = 5'($urandom_range(0, 7));
      iss_t_file   = 2'($urandom_range(0, 3));
      iss_t_idx    = 5'($urandom_range(0, 7));

      @(negedge clk);
      exp_rdy = 1;
      if ((iss_s_file == 2'b01 && mg[iss_s_idx]) || (iss_s_file == 2'b10 && mf[iss_s_idx])) exp_rdy = 0;
      if ((iss_t_file == 2'b01 && mg[iss_t_idx]) || (iss_t_file == 2'b10 && mf[iss_t_idx])) exp_rdy = 0;
      if ((iss_regwrite == 2'b01 && mg[iss_dst]) || (iss_regwrite == 2'b10 && mf[iss_dst])) exp_rdy = 0;
      g = -1;
      for (int k = 1; k <= NPROD; k++) if (g < 0 && pv[(mlast + k) % NPROD]) g = (mlast + k) % NPROD;
      eready = '0;
      if (g >= 0) eready[g] = 1'b1;
      for (int r = 0; r < 32; r++) begin eg[r] = mg[r]; ef[r] = mf[r]; end
      eidle = (eg == 0) && (ef == 0) && (mwb_rw == 2'b00);

      checks++; if (iss_ready !== exp_rdy) begin errors++; $display("FAIL rand_iss_ready cyc=%0d: got %b required %b", cyc, iss_ready, exp_rdy); end
      checks++; if (p_ready !== eready) begin errors++; $display("FAIL rand_p_ready cyc=%0d: got %b required %b", cyc, p_ready, eready); end
      checks++; if (wb_regwrite !== mwb_rw || wb_dst !== mwb_dst || wb_data !== mwb_data) begin
        errors++; $display("FAIL rand_wb cyc=%0d: got %b/%0d/%h required %b/%0d/%h", cyc, wb_regwrite, wb_dst, wb_data, mwb_rw, mwb_dst, mwb_data); end
      checks++; if (gpr_pending !== eg || fpr_pending !== ef) begin
        errors++; $display("FAIL rand_pending cyc=%0d: got %h/%h required %h/%h", cyc, gpr_pending, fpr_pending, eg, ef); end
      checks++; if (idle !== eidle) begin errors++; $display("FAIL rand_idle cyc=%0d: got %b required %b", cyc, idle, eidle); end
      for (int i = 0; i < NPROD; i++) begin
        if (pv[i]) begin
          if (g == i) begin
            checks++; if (pwait[i] > NPROD - 1) begin errors++; $display("FAIL rand_starve p=%0d: got wait %0d required <= %0d", i, pwait[i], NPROD - 1); end
            pwait[i] = 0;
          end else begin
            pwait[i]++;
          end
        end
      end

      if (mwb_rw == 2'b01) mg[mwb_dst] = 0;
      else if (mwb_rw == 2'b10) mf[mwb_dst] = 0;
      if (iss_valid && exp_rdy && (iss_regwrite == 2'b01 || iss_regwrite == 2'b10)) begin
        if (iss_regwrite == 2'b01) mg[iss_dst] = 1; else mf[iss_dst] = 1;
        pool_f.push_back(iss_regwrite);
        pool_d.push_back(iss_dst);
      end
      if (g >= 0) begin
        mwb_rw   = (prw[g] == 2'b01 || prw[g] == 2'b10) ? prw[g] : 2'b00;
        mwb_dst  = pdst[g];
        mwb_data = pdat[g];
        mlast    = g;
        pv[g]    = 0;
      end else begin
        mwb_rw = 2'b00;
      end
      next_cycle();
    end
    clear_inputs();
  endtask

  initial begin
    rst = 1'b1;
    clear_inputs();
    test_reset();
    test_raw_stall();
    test_round_robin();
    test_waw_file();
    test_reset_midflight();
    test_null_request();
    test_random();
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
`default_nettype wire
